// File: rtl/ctrl_disp_pkg.sv
// Shared FIS type constants, frame lengths, target and FSM state encodings for
// the control-FIFO dispatcher.
package ctrl_disp_pkg;

  localparam logic [7:0] FIS_REG_D2H   = 8'h34;
  localparam logic [7:0] FIS_SDB       = 8'hA1;
  localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
  localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
  localparam logic [7:0] FIS_DMA_SETUP = 8'h41;
  localparam logic [7:0] FIS_BIST      = 8'h58;

  localparam logic [2:0] LEN_REG_D2H   = 3'd5;
  localparam logic [2:0] LEN_SDB       = 3'd2;
  localparam logic [2:0] LEN_PIO_SETUP = 3'd5;
  localparam logic [2:0] LEN_DMA_ACT   = 3'd1;
  localparam logic [2:0] LEN_DMA_SETUP = 3'd7;
  localparam logic [2:0] LEN_BIST      = 3'd3;

  typedef enum logic {
    TGT_REG = 1'b0,
    TGT_DMA = 1'b1
  } tgt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/fis_len_decode.sv
// Combinational map from FIS type byte to {known, length in dwords, target path}.
module fis_len_decode
  import ctrl_disp_pkg::*;
(
  input  logic [7:0] fis_type_i,
  output logic       known_o,
  output logic [2:0] len_o,
  output tgt_e       tgt_o
);

  always_comb begin
    known_o = 1'b1;
    len_o   = '0;
    tgt_o   = TGT_REG;
    case (fis_type_i)
      FIS_REG_D2H:   len_o = LEN_REG_D2H;
      FIS_SDB:       len_o = LEN_SDB;
      FIS_PIO_SETUP: len_o = LEN_PIO_SETUP;
      FIS_DMA_ACT:   begin len_o = LEN_DMA_ACT;   tgt_o = TGT_DMA; end
      FIS_DMA_SETUP: begin len_o = LEN_DMA_SETUP; tgt_o = TGT_DMA; end
      FIS_BIST:      begin len_o = LEN_BIST;      tgt_o = TGT_DMA; end
      default:       known_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fis_dispatch.sv
// Control-FIFO FIS dispatcher: decodes the frame type, streams frames to the REG or
// DMA consumer and drops unknown dwords. Stall timeout guarded by CTRL_DISP_TIMEOUT_EN.
module ctrl_fis_dispatch
  import ctrl_disp_pkg::*;
#(
  parameter int unsigned C_TIMEOUT = 1024,
  parameter int unsigned C_CNT_W   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [31:0]        ctrl_data,
  input  logic               ctrl_src_rdy_n,
  output logic               ctrl_dst_rdy1,
  output logic               ctrl_dst_rdy2,
  output logic               ctrl_dst_rdy3,
  output logic               ctrl_dst_lock,
  output logic [31:0]        reg_data,
  output logic               reg_valid,
  output logic               reg_sof,
  output logic               reg_eof,
  input  logic               reg_ready,
  output logic [31:0]        dma_data,
  output logic               dma_valid,
  output logic               dma_sof,
  output logic               dma_eof,
  input  logic               dma_ready,
  output logic [7:0]         fis_type,
  output logic               err_unknown,
  output logic [C_CNT_W-1:0] drop_cnt
);

  state_e             state_q;
  tgt_e               tgt_q;
  logic [2:0]         rem_q;
  logic               first_q;
  logic [7:0]         type_q;
  logic [C_CNT_W-1:0] cnt_q;

  logic       dec_known;
  logic [2:0] dec_len;
  tgt_e       dec_tgt;

  logic have, sel_reg, sel_dma, pop_send, tmo;

  fis_len_decode u_dec (
    .fis_type_i (ctrl_data[7:0]),
    .known_o    (dec_known),
    .len_o      (dec_len),
    .tgt_o      (dec_tgt)
  );

`ifdef CTRL_DISP_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(C_TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q;

  always_comb tmo = (state_q == SEND) && (stall_q == STALL_W'(C_TIMEOUT));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stall_q <= '0;
    end else if (state_q != SEND || pop_send || tmo) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end
`else
  always_comb tmo = 1'b0;
`endif

  // Timeout masks valid so no pop can race the abort in the same cycle.
  always_comb begin
    have     = ~ctrl_src_rdy_n;
    sel_reg  = (state_q == SEND) && (tgt_q == TGT_REG);
    sel_dma  = (state_q == SEND) && (tgt_q == TGT_DMA);

    reg_valid = sel_reg & have & ~tmo;
    dma_valid = sel_dma & have & ~tmo;
    reg_data  = sel_reg ? ctrl_data : '0;
    dma_data  = sel_dma ? ctrl_data : '0;
    reg_sof   = reg_valid & first_q;
    dma_sof   = dma_valid & first_q;
    reg_eof   = (reg_valid & (rem_q == 3'd1)) | (sel_reg & tmo);
    dma_eof   = (dma_valid & (rem_q == 3'd1)) | (sel_dma & tmo);

    pop_send      = (reg_valid & reg_ready) | (dma_valid & dma_ready);
    ctrl_dst_rdy1 = (reg_valid & reg_ready) | ((state_q == DROP) & have);
    ctrl_dst_rdy2 = 1'b0;
    ctrl_dst_rdy3 = dma_valid & dma_ready;
    ctrl_dst_lock = (state_q != IDLE);
    err_unknown   = ((state_q == DROP) & have) | tmo;
    fis_type      = type_q;
    drop_cnt      = cnt_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      tgt_q   <= TGT_REG;
      rem_q   <= '0;
      first_q <= 1'b0;
      type_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (have) begin
            type_q  <= ctrl_data[7:0];
            tgt_q   <= dec_tgt;
            rem_q   <= dec_len;
            first_q <= 1'b1;
            state_q <= dec_known ? SEND : DROP;
          end
        end
        SEND: begin
          if (tmo) begin
            state_q <= IDLE;
          end else if (pop_send) begin
            rem_q   <= rem_q - 3'd1;
            first_q <= 1'b0;
            if (rem_q == 3'd1) state_q <= IDLE;
          end
        end
        DROP: begin
          if (have) begin
            if (~&cnt_q) cnt_q <= cnt_q + C_CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fis_dispatch.sv
// Directed bench for ctrl_fis_dispatch: FWFT FIFO model, frame capture and
// hand-computed expectations. Timeout case compiled only with CTRL_DISP_TIMEOUT_EN.
module tb_ctrl_fis_dispatch;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] ctrl_data = '0;
  logic        ctrl_src_rdy_n = 1'b1;
  logic        ctrl_dst_rdy1, ctrl_dst_rdy2, ctrl_dst_rdy3, ctrl_dst_lock;
  logic [31:0] reg_data, dma_data;
  logic        reg_valid, reg_sof, reg_eof, dma_valid, dma_sof, dma_eof;
  logic        reg_ready = 1'b0;
  logic        dma_ready = 1'b0;
  logic [7:0]  fis_type;
  logic        err_unknown;
  logic [7:0]  drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];
  logic [31:0] cap_reg[$], cap_dma[$];
  logic        reg_sof_q[$], reg_eof_q[$], dma_sof_q[$], dma_eof_q[$];
  int unsigned pops1, pops3, lock_cyc, err_cyc, both_cyc, bad_pop, rv_seen, dv_seen;
  bit          dma_toggle = 1'b0;

  always #5 sys_clk = ~sys_clk;

  ctrl_fis_dispatch #(.C_TIMEOUT(16), .C_CNT_W(8)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .ctrl_data      (ctrl_data),
    .ctrl_src_rdy_n (ctrl_src_rdy_n),
    .ctrl_dst_rdy1  (ctrl_dst_rdy1),
    .ctrl_dst_rdy2  (ctrl_dst_rdy2),
    .ctrl_dst_rdy3  (ctrl_dst_rdy3),
    .ctrl_dst_lock  (ctrl_dst_lock),
    .reg_data       (reg_data),
    .reg_valid      (reg_valid),
    .reg_sof        (reg_sof),
    .reg_eof        (reg_eof),
    .reg_ready      (reg_ready),
    .dma_data       (dma_data),
    .dma_valid      (dma_valid),
    .dma_sof        (dma_sof),
    .dma_eof        (dma_eof),
    .dma_ready      (dma_ready),
    .fis_type       (fis_type),
    .err_unknown    (err_unknown),
    .drop_cnt       (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    ctrl_src_rdy_n = (fifo.size() == 0);
    ctrl_data      = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic clear_stats();
    pops1 = 0; pops3 = 0; lock_cyc = 0; err_cyc = 0;
    both_cyc = 0; bad_pop = 0; rv_seen = 0; dv_seen = 0;
    cap_reg.delete(); cap_dma.delete();
    reg_sof_q.delete(); reg_eof_q.delete(); dma_sof_q.delete(); dma_eof_q.delete();
  endtask

  // Each cycle: drive at posedge+1, observe at negedge, pop the model at the edge.
  task automatic run(input int unsigned n);
    bit p;
    for (int unsigned i = 0; i < n; i++) begin
      if (dma_toggle) dma_ready = (i % 2 == 0);
      drive_fifo();
      @(negedge sys_clk);
      p = ctrl_dst_rdy1 | ctrl_dst_rdy3;
      pops1 += ctrl_dst_rdy1;
      pops3 += ctrl_dst_rdy3;
      lock_cyc += ctrl_dst_lock;
      err_cyc += err_unknown;
      both_cyc += (ctrl_dst_rdy1 & ctrl_dst_rdy3);
      rv_seen += reg_valid;
      dv_seen += dma_valid;
      if ((ctrl_dst_rdy3 && !dma_ready) || (ctrl_dst_rdy1 && reg_valid && !reg_ready)) bad_pop++;
      if (reg_valid && reg_ready) begin
        cap_reg.push_back(reg_data); reg_sof_q.push_back(reg_sof); reg_eof_q.push_back(reg_eof);
      end
      if (dma_valid && dma_ready) begin
        cap_dma.push_back(dma_data); dma_sof_q.push_back(dma_sof); dma_eof_q.push_back(dma_eof);
      end
      @(posedge sys_clk);
      #1;
      if (p && fifo.size() != 0) void'(fifo.pop_front());
    end
    drive_fifo();
  endtask

  task automatic push_frame(input logic [7:0] t, input int unsigned len, input logic [31:0] base);
    exp_q.delete();
    for (int unsigned i = 0; i < len; i++) begin
      logic [31:0] w;
      w = (i == 0) ? {24'h5A5A00, t} : base + i;
      fifo.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_stream(input string tag, input bit dma);
    int unsigned n;
    n = dma ? cap_dma.size() : cap_reg.size();
    check({tag, "_len"}, n, exp_q.size());
    for (int unsigned i = 0; i < exp_q.size(); i++)
      check({tag, "_data"}, dma ? cap_dma[i] : cap_reg[i], exp_q[i]);
    check({tag, "_sof"}, dma ? dma_sof_q[0] : reg_sof_q[0], 1);
    check({tag, "_eof"}, dma ? dma_eof_q[n-1] : reg_eof_q[n-1], 1);
    if (n > 1) begin
      check({tag, "_sof_last"}, dma ? dma_sof_q[n-1] : reg_sof_q[n-1], 0);
      check({tag, "_eof_first"}, dma ? dma_eof_q[0] : reg_eof_q[0], 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_lock", ctrl_dst_lock, 0);
    check("rst_rdy", {ctrl_dst_rdy1, ctrl_dst_rdy2, ctrl_dst_rdy3}, 0);
    check("rst_valid", {reg_valid, dma_valid}, 0);
    check("rst_type", fis_type, 0);
    check("rst_cnt", drop_cnt, 0);
    check("rst_err", err_unknown, 0);
    sys_rst = 1'b0;

    // 0x34: 5-dword REG frame with ready held high
    reg_ready = 1'b1; dma_ready = 1'b0;
    push_frame(8'h34, 5, 32'hA000_0000);
    clear_stats(); run(8);
    check("d2h_pops1", pops1, 5);
    check("d2h_pops3", pops3, 0);
    check("d2h_lock", lock_cyc, 5);
    check("d2h_dmav", dv_seen, 0);
    check("d2h_type", fis_type, 8'h34);
    check_stream("d2h", 1'b0);

    // 0x41: 7-dword DMA frame with ready toggling
    reg_ready = 1'b0; dma_toggle = 1'b1;
    push_frame(8'h41, 7, 32'hD000_0000);
    clear_stats(); run(20);
    dma_toggle = 1'b0;
    check("dsu_pops3", pops3, 7);
    check("dsu_pops1", pops1, 0);
    check("dsu_badpop", bad_pop, 0);
    check("dsu_regv", rv_seen, 0);
    check("dsu_both", both_cyc, 0);
    check("dsu_lock_end", ctrl_dst_lock, 0);
    check_stream("dsu", 1'b1);

    // unknown dword then a 1-dword DMA frame
    dma_ready = 1'b1;
    fifo.push_back(32'h0000_00FF);
    push_frame(8'h39, 1, 32'h0);
    clear_stats(); run(6);
    check("unk_err", err_cyc, 1);
    check("unk_cnt", drop_cnt, 1);
    check("unk_pops1", pops1, 1);
    check("act_pops3", pops3, 1);
    check("act_type", fis_type, 8'h39);
    check_stream("act", 1'b1);

    // 0xA1 with 4 empty cycles between dword0 and dword1
    reg_ready = 1'b1;
    push_frame(8'hA1, 1, 32'hB000_0000);
    clear_stats(); run(2);
    check("sdb_first_pop", pops1, 1);
    clear_stats(); run(4);
    check("sdb_gap_valid", rv_seen, 0);
    check("sdb_gap_pops", pops1 + pops3, 0);
    check("sdb_gap_lock", lock_cyc, 4);
    fifo.push_back(32'hB000_0001);
    clear_stats(); run(3);
    check("sdb_tail_pops", pops1, 1);
    check("sdb_tail_data", cap_reg[0], 32'hB000_0001);
    check("sdb_tail_eof", reg_eof_q[0], 1);
    check("sdb_tail_sof", reg_sof_q[0], 0);
    check("sdb_done_lock", ctrl_dst_lock, 0);

    // 299 more unknown dwords: 300 in total, counter saturates
    for (int unsigned i = 0; i < 299; i++) fifo.push_back({i[23:0], 8'h00});
    clear_stats(); run(610);
    check("sat_err", err_cyc, 299);
    check("sat_cnt", drop_cnt, 255);
    check("sat_empty", fifo.size(), 0);

    // reset in the middle of a 0x5F frame
    push_frame(8'h5F, 5, 32'hC000_0000);
    clear_stats(); run(3);
    check("pio_pre_pops", pops1, 2);
    #2;
    sys_rst = 1'b1;
    fifo.delete(); drive_fifo();
    #1;
    check("mrst_lock", ctrl_dst_lock, 0);
    check("mrst_valid", {reg_valid, dma_valid, reg_sof, reg_eof}, 0);
    check("mrst_rdy", {ctrl_dst_rdy1, ctrl_dst_rdy3}, 0);
    check("mrst_type", fis_type, 0);
    check("mrst_cnt", drop_cnt, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    clear_stats(); run(3);
    check("mrst_idle_lock", lock_cyc, 0);

    // recovery: 0x58 DMA frame
    push_frame(8'h58, 3, 32'hE000_0000);
    clear_stats(); run(6);
    check("bist_pops3", pops3, 3);
    check_stream("bist", 1'b1);

`ifdef CTRL_DISP_TIMEOUT_EN
    // stall SEND: 16 no-pop cycles, abort on the 17th
    reg_ready = 1'b0;
    fifo.push_back(32'h5A5A_0034);
    clear_stats(); run(17);
    check("tmo_no_err", err_cyc, 0);
    check("tmo_lock", lock_cyc, 16);
    drive_fifo();
    @(negedge sys_clk);
    check("tmo_err", err_unknown, 1);
    check("tmo_eof", reg_eof, 1);
    check("tmo_valid", reg_valid, 0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("tmo_idle_lock", ctrl_dst_lock, 0);
    sys_rst = 1'b1; fifo.delete(); drive_fifo();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_fis_dispatch.md
Name: ctrl_fis_dispatch

Overview:
- Sits in the sys_clk domain on the read side of the link-layer control FIFO: FWFT data `ctrl_data`, empty flag `ctrl_src_rdy_n`.
- Decodes the FIS type in the first dword of each frame and derives the frame length from the type.
- Streams the frame to one of two consumers: the register path (REG) or the DMA/BIST path (DMA).
- Generates the FIFO pop strobes (`ctrl_dst_rdy1/3`) and `ctrl_dst_lock`. Unknown types are discarded one dword at a time and counted.

Parameters:
- C_TIMEOUT, 1024: stall cycles in SEND before the frame is aborted (used only with the optional feature).
- C_CNT_W, 8: width of the saturating drop counter.

Ports:
- sys_clk  in  1  block clock.
- sys_rst  in  1  asynchronous, active-high reset.
- ctrl_data  in  32  FIFO head dword (FWFT); `[7:0]` = FIS type on the first dword.
- ctrl_src_rdy_n  in  1  FIFO empty; 1 = no data.
- ctrl_dst_rdy1  out  1  FIFO pop strobe for REG transfers and drops.
- ctrl_dst_rdy2  out  1  reserved; always 0.
- ctrl_dst_rdy3  out  1  FIFO pop strobe for DMA transfers.
- ctrl_dst_lock  out  1  frame in progress; holds off the link side.
- reg_data  out  32  REG path data.
- reg_valid  out  1  REG path data valid.
- reg_sof  out  1  REG path first dword of frame.
- reg_eof  out  1  REG path last dword of frame.
- reg_ready  in  1  REG consumer accepts data.
- dma_data  out  32  DMA path data.
- dma_valid  out  1  DMA path data valid.
- dma_sof  out  1  DMA path first dword of frame.
- dma_eof  out  1  DMA path last dword of frame.
- dma_ready  in  1  DMA consumer accepts data.
- fis_type  out  8  type byte latched for the current or last frame.
- err_unknown  out  1  one-cycle pulse per dropped dword.
- drop_cnt  out  C_CNT_W  saturating count of dropped dwords.

Behaviour:
- Reset (async, sys_rst=1):
  - state=IDLE.
  - All outputs 0, including all strobes, valids, lock, `fis_type` and `drop_cnt`.
  - The FIFO shares sys_rst, so no partial frame survives reset. A reset mid-frame simply returns to IDLE.
- Type table (type -> dwords, target):
  - 0x34 -> 5, REG
  - 0xA1 -> 2, REG
  - 0x5F -> 5, REG
  - 0x39 -> 1, DMA
  - 0x41 -> 7, DMA
  - 0x58 -> 3, DMA
  - anything else -> unknown.
- State IDLE:
  - When `ctrl_src_rdy_n`=0, latch `fis_type` = `ctrl_data[7:0]`, target, and remaining count `rem` = length.
  - Known type: go to SEND. Unknown type: go to DROP.
  - No pop occurs in IDLE, so each frame costs 1 bubble cycle.
- State SEND:
  - Selected-path `_data` = `ctrl_data`, combinational, 0 latency.
  - `_valid` = ~`ctrl_src_rdy_n`.
  - `_sof` = first dword of the frame; `_eof` = (`rem`==1).
  - Pop when valid and the selected ready are both 1: REG pops on `ctrl_dst_rdy1`, DMA pops on `ctrl_dst_rdy3`. Pop strobes are combinational and asserted only in that cycle.
  - On each pop `rem` decrements. When the pop coincides with `rem`==1, go to IDLE.
  - FIFO empty mid-frame: valid=0, no pop, state held.
  - Ready without valid has no effect.
  - The non-selected path stays at valid=0.
- State DROP:
  - Pop exactly 1 dword via `ctrl_dst_rdy1` while not empty.
  - Pulse `err_unknown` and increment `drop_cnt`, saturating at all-ones.
  - Return to IDLE.
- `ctrl_dst_lock` = 1 in SEND and DROP, 0 in IDLE. It is combinational from the state register.
- `ctrl_dst_rdy1` and `ctrl_dst_rdy3` are never both 1 in the same cycle.

Optional Feature:
- CTRL_DISP_TIMEOUT_EN defined:
  - A stall counter clears on every pop and on entry to SEND, and increments in SEND on each cycle with no pop.
  - When it reaches C_TIMEOUT: assert the selected `_eof` with valid=0, pulse `err_unknown`, and go to IDLE. The remaining words of that frame are then decoded as new frames.
- Undefined: SEND waits indefinitely and no counter logic exists.

Decomposition:
- Package ctrl_disp_pkg holds:
  - FIS type constants: FIS_REG_D2H, FIS_SDB, FIS_PIO_SETUP, FIS_DMA_ACT, FIS_DMA_SETUP, FIS_BIST.
  - Their lengths.
  - Target encoding (TGT_REG, TGT_DMA).
  - State encoding: IDLE, SEND, DROP.
- One sub-module: fis_len_decode, a combinational map from type byte to {known, len[2:0], tgt}.

Test Plan:
- 0x34 frame (5 dwords), reg_ready=1 -> reg_sof on dword0, reg_eof on dword4, 5 `ctrl_dst_rdy1` pulses, lock high for exactly 5 cycles, dma_valid=0 throughout.
- 0x41 frame (7 dwords), dma_ready toggling 1/0 -> 7 `ctrl_dst_rdy3` pops, data in order, no pop while ready=0.
- Dword 0x000000FF then a 0x39 frame -> err_unknown pulses once, drop_cnt=1, then a 1-dword DMA frame with sof=eof=1.
- Frame 0xA1 with the FIFO empty between dword0 and dword1 for 4 cycles -> valid=0 and no pops during the gap, lock stays 1, frame completes.
- 300 unknown dwords with C_CNT_W=8 -> drop_cnt saturates at 255. Then assert sys_rst mid-0x5F frame -> all outputs 0 immediately, state IDLE.
- With CTRL_DISP_TIMEOUT_EN and C_TIMEOUT=16: stall SEND for 16 cycles -> err_unknown pulse, return to IDLE, lock=0.
